// File: rtl/spi_shader_loader.sv
// spi_shader_loader
//   SPI master (mode 0, MSB first) that streams shader instruction bytes from a
//   valid/ready byte interface into the shader's SPI slave port. Each frame of
//   bytes (terminated by in_last) is wrapped in one active-low spi_cs window.
//
//   Optional feature macro: SPI_SHADER_LOADER_READBACK_EN
//     defined   : spi_miso is shifted in on every rising sclk edge and the
//                 completed byte is presented on rx_data with a one-cycle
//                 rx_valid strobe at the 8th falling edge.
//     undefined : rx_data/rx_valid are tied to 0 and spi_miso is ignored.
//
//   Parameter
//     CLK_DIV  : SCLK half-period in clk cycles (1..255)
//
//   Ports
//     clk, rst_n          : system clock, asynchronous active-low reset
//     in_data, in_last    : byte to send and end-of-frame marker
//     in_valid, in_ready  : byte handshake (accepted when both are high)
//     busy                : high while a frame holds spi_cs low
//     spi_cs, spi_sclk    : chip select (active low), SPI clock (idle low)
//     spi_mosi, spi_miso  : serial data out / in
//     rx_data, rx_valid   : readback byte and its strobe
module spi_shader_loader #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        BYTE_END,
        HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic       half;      // 0: low half of a bit, 1: high half
    logic [7:0] tx_sh;
    logic       last_q;
    logic       div_done;
    logic       accept;

    assign div_done = (div_cnt == DIV_LAST);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            half     <= 1'b0;
            tx_sh    <= '0;
            last_q   <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            case (state)
                IDLE, BYTE_END: begin
                    // in_ready is registered, so it is already high on the
                    // first cycle of either waiting state.
                    if (accept) begin
                        tx_sh    <= in_data;
                        last_q   <= in_last;
                        spi_mosi <= in_data[7];
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        div_cnt  <= '0;
                        state    <= LEAD;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LEAD: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        half    <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!half) begin
                            half     <= 1'b1;
                            spi_sclk <= 1'b1;
                        end else begin
                            half     <= 1'b0;
                            spi_sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                // mosi keeps bit0 through HOLD/BYTE_END
                                if (last_q) begin
                                    state <= HOLD;
                                end else begin
                                    state    <= BYTE_END;
                                    in_ready <= 1'b1;
                                end
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                                spi_mosi <= tx_sh[6];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        spi_cs   <= 1'b1;
                        busy     <= 1'b0;
                        spi_mosi <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SHADER_LOADER_READBACK_EN
    logic       sclk_rise;
    logic       last_fall;
    logic [7:0] rx_sh;

    assign sclk_rise = (state == SHIFT) && !half && div_done;
    assign last_fall = (state == SHIFT) && half && div_done && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sclk_rise) begin
                rx_sh <= {rx_sh[6:0], spi_miso};
            end
            // the final rise has already shifted bit0 into rx_sh
            if (last_fall) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: doc/spi_shader_loader.md
Name: spi_shader_loader

Overview:
- SPI master (mode 0, MSB first) that drives the shader's SPI slave port (spi_cs, spi_mosi, spi_sclk, spi_miso).
- Takes a valid/ready byte stream of shader instruction bytes and frames each transfer with spi_cs.
- Used in the FPGA/harness build to load shader memory without an external MCU.
- Optionally captures MISO readback bytes.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk cycles (H); legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  byte to transmit
- in_last  input  1  qualifies in_data; marks the final byte of a frame
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  loader accepts a byte this cycle when in_valid is also high
- busy  output  1  high from the accept cycle until spi_cs returns high
- spi_cs  output  1  active-low chip select
- spi_sclk  output  1  SPI clock, idle low
- spi_mosi  output  1  serial data out
- spi_miso  input  1  serial data in
- rx_data  output  8  last received byte (readback feature only; otherwise tied 0)
- rx_valid  output  1  one-cycle strobe, rx_data updated (readback feature only; otherwise tied 0)

Behaviour:
- Interface: one clock domain; rst_n asynchronous, active-low, asserts immediately and is released synchronously to clk.
- Reset values: spi_cs=1, spi_sclk=0, spi_mosi=0, in_ready=0 during reset, busy=0, rx_data=0, rx_valid=0. State goes to IDLE and the divider and bit counters clear.
- Reset mid-transfer aborts the transfer immediately. No partial byte is emitted after reset release.
- States: IDLE, LEAD, SHIFT, BYTE_END, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch the byte and in_last, go to LEAD.
  - spi_cs goes low and spi_mosi=bit7 on the next cycle.
- LEAD:
  - Lasts H cycles with sclk low, then go to SHIFT.
- SHIFT:
  - 8 bits, each of 2H cycles.
  - spi_sclk rises at the start of each bit's second half.
  - spi_miso is sampled on the rising edge.
  - On each falling edge, spi_mosi advances to the next lower bit; spi_mosi holds bit0 after the last fall.
  - After the 8th fall: go to HOLD if the latched last=1, else go to BYTE_END.
- BYTE_END:
  - in_ready=1; spi_cs stays low and spi_sclk stays low.
  - On accept: latch the byte, set spi_mosi=bit7, go to LEAD.
  - Waits indefinitely without in_valid; spi_cs is held low across the stall.
- HOLD:
  - Lasts H cycles, then spi_cs=1, busy=0, go to IDLE.
  - in_ready=1 only from the IDLE cycle following HOLD, giving at least one cycle of cs-high gap.
- in_ready is 0 in LEAD, SHIFT and HOLD. in_data changes while in_ready=0 are ignored.
- Timing, single-byte frame: spi_cs low exactly 18H clk cycles.
- Timing, each additional back-to-back byte (in_valid held): adds 17H+1 cycles.
- Exactly 8 sclk rising edges per byte; spi_sclk is low whenever spi_cs is high.

Optional Feature:
- Macro: SPI_SHADER_LOADER_READBACK_EN.
- Defined: a shift-in register captures spi_miso on each rising sclk edge, MSB first.
  - On the 8th falling edge, rx_data is loaded and rx_valid pulses for 1 cycle.
  - rx_data holds until the next byte completes.
- Undefined: rx_data=0 and rx_valid=0 constantly; no capture logic is synthesized; spi_miso is unused.

Test Plan:
- Reset, then idle 20 cycles -> spi_cs=1, spi_sclk=0, spi_mosi=0, in_ready=1, busy=0.
- CLK_DIV=2, send 0xA5 with last=1 -> MOSI sampled on rising edges = 1,0,1,0,0,1,0,1; exactly 8 rises; spi_cs low 36 cycles; busy falls when spi_cs rises.
- CLK_DIV=2, send 0x3C then 0xFF (last) back-to-back -> single spi_cs low window of 71 cycles; 16 rises; bits 00111100 11111111.
- Send 0x12 (last=0), drop in_valid for 50 cycles, then send 0x34 (last=1) -> spi_cs stays low and sclk stays low during the stall; 16 rises total; frame ends after 0x34.
- Assert rst_n=0 mid-SHIFT of 0xF0 -> spi_cs=1, spi_sclk=0 asynchronously; after release, IDLE with no extra sclk edges.
- READBACK_EN, bench slave drives MISO 0x5A while loader sends 0x00 (last) -> rx_valid pulses once, rx_data=0x5A.
